// File: rtl/mult_control.sv
// Sequencing FSM for the shift-add multiplier: drives datapath selects from start/b_lsb.
// Latency: start sampled on cycle 0, CALC on cycles 1..WIDTH, done pulse on cycle WIDTH+1.
// No backpressure: start is only accepted in IDLE and ignored (not queued) otherwise.
module mult_control #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_b_lsb,
   output logic             o_a_sel,
   output logic             o_b_sel,
   output logic             o_prod_sel,
   output logic             o_add_sel,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_iter
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Last iteration index; reaching it in CALC ends the operation.
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_iter;
   logic [CNT_W-1:0] w_iter_next;

   // State and iteration counter registers; reset abandons any in-flight operation.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_iter  <= '0;
      end else begin
         r_state <= w_state_next;
         r_iter  <= w_iter_next;
      end
   end

   // Next-state, counter and select decode; only add_sel and IDLE prod_sel look at inputs.
   always_comb begin
      w_state_next = r_state;
      w_iter_next  = r_iter;
      o_a_sel      = 1'b0;
      o_b_sel      = 1'b0;
      o_prod_sel   = 1'b1;
      o_add_sel    = 1'b1;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Operands load unconditionally; product clears only when starting.
            o_prod_sel = ~i_start;
            if (i_start) begin
               w_state_next = S_CALC;
               w_iter_next  = '0;
            end
         end
         S_CALC: begin
            o_a_sel     = 1'b1;
            o_b_sel     = 1'b1;
            o_add_sel   = ~i_b_lsb;
            o_busy      = 1'b1;
            w_iter_next = r_iter + CNT_W'(1);
            if (r_iter == LAST_ITER) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            // Counter already reads WIDTH here and keeps it until the next start.
            o_done       = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign o_iter = r_iter;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: table of single-cycle vectors plus multi-cycle sequences
// driving a behavioural shift-add datapath from the controller selects.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after it.
module tb_mult_control;

   logic        clk;
   logic        reset;
   logic        start;
   logic        b_lsb;
   logic        a_sel;
   logic        b_sel;
   logic        prod_sel;
   logic        add_sel;
   logic        busy;
   logic        done;
   logic [5:0]  iter;

   logic [31:0] ext_a;
   logic [31:0] ext_b;
   logic [63:0] m_a;
   logic [31:0] m_b;
   logic [63:0] m_p;
   logic        use_model;
   logic        tb_lsb;

   int n_vec;
   int n_bad;

   mult_control #(.WIDTH(32), .CNT_W(6)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_start    (start),
      .i_b_lsb    (b_lsb),
      .o_a_sel    (a_sel),
      .o_b_sel    (b_sel),
      .o_prod_sel (prod_sel),
      .o_add_sel  (add_sel),
      .o_busy     (busy),
      .o_done     (done),
      .o_iter     (iter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign b_lsb = use_model ? m_b[0] : tb_lsb;

   // Behavioural datapath: registers without enables, steered only by the selects.
   always @(posedge clk) begin
      if (reset) begin
         m_a <= 64'd0;
         m_b <= 32'd0;
         m_p <= 64'd0;
      end else begin
         m_a <= a_sel ? (m_a << 1) : {32'd0, ext_a};
         m_b <= b_sel ? (m_b >> 1) : ext_b;
         m_p <= !prod_sel ? 64'd0 : (add_sel ? m_p : m_p + m_a);
      end
   end

   typedef struct {
      logic       rst;
      logic       st;
      logic       lsb;
      logic [5:0] exp_sel;   // {a_sel, b_sel, prod_sel, add_sel, busy, done}
      logic [5:0] exp_iter;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic begin_cycle();
      @(posedge clk);
      #1;
   endtask

   // One operation from IDLE; optionally pulses start again (with other operands) mid-flight.
   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int restart_cyc,
                         output logic any_add0, output logic any_add1);
      any_add0 = 1'b0;
      any_add1 = 1'b0;
      begin_cycle();
      ext_a = a;
      ext_b = b;
      start = 1'b1;
      #1;
      chk({nm, "_c0_prod_sel"}, 64'(prod_sel), 64'd0);
      for (int c = 1; c <= 33; c++) begin
         begin_cycle();
         start = (c == restart_cyc);
         if (c == restart_cyc) begin
            ext_a = 32'd100;
            ext_b = 32'd100;
         end
         #1;
         chk($sformatf("%s_busy_done_c%0d", nm, c), 64'({busy, done}),
             64'({(c <= 32), (c == 33)}));
         if (busy) begin
            if (!add_sel) any_add0 = 1'b1;
            else          any_add1 = 1'b1;
         end
         if (c == 33) begin
            chk({nm, "_prod"}, m_p, exp);
            chk({nm, "_iter_done"}, 64'(iter), 64'd32);
            chk({nm, "_done_sels"}, 64'({a_sel, b_sel, prod_sel, add_sel, busy, done}),
                64'(6'b001101));
         end
      end
      start = 1'b0;
   endtask

   initial begin
      logic a0;
      logic a1;
      logic saw_done;
      n_vec     = 0;
      n_bad     = 0;
      reset     = 1'b1;
      start     = 1'b0;
      use_model = 1'b0;
      tb_lsb    = 1'b0;
      ext_a     = 32'd0;
      ext_b     = 32'd0;

      vt[0] = '{1'b1, 1'b0, 1'b0, 6'b001100, 6'd0};
      vt[1] = '{1'b1, 1'b1, 1'b0, 6'b000100, 6'd0};
      vt[2] = '{1'b0, 1'b0, 1'b1, 6'b001100, 6'd0};
      vt[3] = '{1'b0, 1'b1, 1'b1, 6'b000100, 6'd0};
      vt[4] = '{1'b0, 1'b0, 1'b1, 6'b111010, 6'd0};
      vt[5] = '{1'b0, 1'b1, 1'b0, 6'b111110, 6'd1};
      vt[6] = '{1'b0, 1'b0, 1'b1, 6'b111010, 6'd2};
      vt[7] = '{1'b1, 1'b0, 1'b0, 6'b111110, 6'd3};
      vt[8] = '{1'b0, 1'b0, 1'b0, 6'b001100, 6'd0};

      // Establish a known state before the table.
      begin_cycle();
      begin_cycle();

      // Single-cycle vectors with b_lsb forced by the bench.
      for (int i = 0; i < 9; i++) begin
         begin_cycle();
         reset  = vt[i].rst;
         start  = vt[i].st;
         tb_lsb = vt[i].lsb;
         #1;
         chk($sformatf("vec%0d", i),
             64'({a_sel, b_sel, prod_sel, add_sel, busy, done, iter}),
             64'({vt[i].exp_sel, vt[i].exp_iter}));
      end
      start     = 1'b0;
      reset     = 1'b0;
      use_model = 1'b1;
      begin_cycle();

      // Basic operation, then the result must hold through idle cycles.
      run_op("op3x5", 32'd3, 32'd5, 64'd15, -1, a0, a1);
      for (int i = 0; i < 10; i++) begin
         begin_cycle();
         #1;
         chk($sformatf("hold15_c%0d", i), m_p, 64'd15);
      end

      run_op("opmax", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, -1, a0, a1);
      chk("opmax_add_sel_never_hold", 64'(a1), 64'd0);

      run_op("opzero", 32'h12345678, 32'd0, 64'd0, -1, a0, a1);
      chk("opzero_add_sel_never_add", 64'(a0), 64'd0);

      // Second start on cycle 10 is ignored; result is for 3*5.
      run_op("restart", 32'd3, 32'd5, 64'd15, 10, a0, a1);

      // Start held high: back-to-back operations done on cycles 33 and 67.
      ext_a = 32'd7;
      ext_b = 32'd6;
      for (int c = 0; c < 80; c++) begin
         begin_cycle();
         start = 1'b1;
         #1;
         chk($sformatf("held_done_c%0d", c), 64'(done), 64'((c == 33) || (c == 67)));
         if ((c == 33) || (c == 67)) begin
            chk($sformatf("held_prod_c%0d", c), m_p, 64'd42);
         end
      end
      start = 1'b0;
      for (int i = 0; i < 40; i++) begin
         begin_cycle();
      end

      // Reset on cycle 15 aborts the operation without a done pulse.
      begin_cycle();
      ext_a = 32'd3;
      ext_b = 32'd5;
      start = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         begin_cycle();
         start = 1'b0;
         reset = (c == 15);
      end
      begin_cycle();
      reset = 1'b0;
      #1;
      chk("abort_c16", 64'({a_sel, busy, done, iter}), 64'd0);
      saw_done = 1'b0;
      for (int c = 17; c <= 45; c++) begin
         begin_cycle();
         #1;
         if (done) saw_done = 1'b1;
      end
      chk("abort_no_done", 64'(saw_done), 64'd0);
      run_op("after_abort", 32'd9, 32'd11, 64'd99, -1, a0, a1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
